// File: rtl/seq_multiplier.sv
// Multi-cycle shift-and-add multiplier: latches x/y on start, one operand bit per clock.
// Optional macro SIGNED_MUL_EN selects two's-complement operands (sign-magnitude iteration).
module seq_multiplier #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     x,
  input  logic [WIDTH-1:0]     y,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          state_q;
  logic [PW-1:0]   a_q;
  logic [PW-1:0]   acc_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]   cnt_q;
  logic            busy_q;
  logic            done_q;
  logic [PW-1:0]   product_q;

  logic [PW-1:0]    acc_d;
  logic [PW-1:0]    product_d;
  logic [WIDTH-1:0] x_mag;
  logic [WIDTH-1:0] y_mag;
  logic             last_step;

  // One iteration: conditionally add the shifted multiplicand.
  always_comb begin
    acc_d     = acc_q;
    if (b_q[0]) begin
      acc_d = PW'(acc_q + a_q);
    end
    last_step = (cnt_q == CW'(WIDTH - 1));
  end

`ifdef SIGNED_MUL_EN
  logic sign_q;

  // Magnitudes feed the unsigned core; -2^(WIDTH-1) maps to 2^(WIDTH-1) unsigned.
  always_comb begin
    x_mag     = x[WIDTH-1] ? WIDTH'(-x) : x;
    y_mag     = y[WIDTH-1] ? WIDTH'(-y) : y;
    product_d = sign_q ? PW'(-acc_d) : acc_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sign_q <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      sign_q <= x[WIDTH-1] ^ y[WIDTH-1];
    end
  end
`else
  always_comb begin
    x_mag     = x;
    y_mag     = y;
    product_d = acc_d;
  end
`endif

  // Control FSM and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            a_q     <= {{WIDTH{1'b0}}, x_mag};
            b_q     <= y_mag;
            acc_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          acc_q <= acc_d;
          a_q   <= a_q << 1;
          b_q   <= b_q >> 1;
          cnt_q <= CW'(cnt_q + 1'b1);
          if (last_step) begin
            product_q <= product_d;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            state_q   <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: doc/seq_multiplier.md
# seq_multiplier

Multi-cycle shift-and-add unsigned multiplier for the calculator datapath. It sits directly downstream of the shared y register (its `to_multiplier` output) and the x register. It latches both operands on `start`, iterates one operand bit per clock, and returns a double-width product with a one-cycle `done` pulse. The result feeds the calculator's result/display path.

## Interface

Parameters:
- `WIDTH`, default 4: operand width in bits. The product is 2·WIDTH bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  request. Sampled only in IDLE.
- `x`  in  WIDTH  multiplicand, from the x register.
- `y`  in  WIDTH  multiplier, from the shared y register's multiplier output.
- `busy`  out  1  high while in RUN.
- `done`  out  1  one-cycle pulse; high exactly while in DONE.
- `product`  out  2·WIDTH  last completed result; holds until the next completion.

## Operation

- States: IDLE, RUN, DONE. The state encoding is internal.
- Internal registers:
  - `a` (2·WIDTH), multiplicand shifted left each step.
  - `b` (WIDTH), multiplier shifted right each step.
  - `acc` (2·WIDTH).
  - `cnt` (a counter wide enough to reach WIDTH).
- **IDLE**
  - With `start`=1: load `a`={0,x}, `b`=y, `acc`=0, `cnt`=0, go to RUN.
  - With `start`=0: stay in IDLE; no register changes.
- **RUN**, per edge:
  - If `b[0]`, `acc` ← `acc`+`a` (modulo 2^(2·WIDTH); overflow cannot occur for unsigned operands).
  - `a` ← `a`<<1, `b` ← `b`>>1, `cnt` ← `cnt`+1.
  - On the edge where `cnt`==WIDTH−1: load `product` with the final sum (including this step's add) and go to DONE.
- **DONE**: lasts one cycle, then go to IDLE unconditionally.
- There is no early exit: zero operands still take all WIDTH iterations.
- `x` and `y` are don't-care after the start edge. Later changes must not affect the result.
- `start` asserted in RUN or DONE is ignored. It is not queued.
- Reset, at any time including mid-RUN: state=IDLE, `busy`=0, `done`=0, `product`=0. The operation in progress is discarded.

## Timing

- Call the edge that samples `start` in IDLE "edge 0".
  - Edges 1..WIDTH perform the iterations.
  - Edge WIDTH loads `product` and asserts `done`.
  - Edge WIDTH+1 deasserts `done` and returns to IDLE.
- Latency from start-sample edge to `done`=1: WIDTH cycles (4 for the default width).
- `busy` is high from edge 0 to edge WIDTH. It is low in DONE and in IDLE.
- `product` changes only on the `done`-asserting edge and on reset. It is valid from the cycle `done` is high.
- Earliest next start: `start` high in the cycle after `done` (IDLE) is sampled at edge WIDTH+2. Throughput is one product per WIDTH+2 cycles.
- Reset values: `busy`=0, `done`=0, `product`=0.

## Configuration

- `SIGNED_MUL_EN`
  - **Defined**: `x` and `y` are two's-complement.
    - In IDLE the block latches the magnitudes |x| and |y|, and records the sign as `x[MSB]` XOR `y[MSB]`.
    - The iteration is unchanged.
    - On the DONE edge, `product` is loaded with the negated sum if the recorded sign is 1.
    - Latency and handshake are identical to the unsigned build.
    - For −2^(WIDTH−1), the magnitude is 2^(WIDTH−1), held in WIDTH bits as an unsigned value.
  - **Undefined**: purely unsigned, as described above. No sign logic is synthesized.

## Test plan

- **Maximum operands.** Reset, then x=15, y=15, `start` pulse → `busy` high 4 cycles; `done` one cycle at 4 cycles after the start edge; `product`=0xE1 (225), held after `done` falls.
- **Zero operand.** x=0, y=9 → `product`=0x00 with identical latency. Also x=7, y=1 → 0x07.
- **Start while busy.** x=3, y=5, start; then x=15, y=15 with `start` held high through RUN and DONE → `product`=0x0F. The held `start` is accepted only when IDLE is reached, and the second result is 0xE1 at the following `done`.
- **Operand change after start.** Change `x`/`y` on the cycle after the start edge (x=2, y=6 latched, then x=9, y=9) → `product`=0x0C.
- **Reset mid-operation.** Start 15×15, assert `rst` during the 2nd RUN cycle → `busy`=0, `done`=0, `product`=0 immediately; no `done` pulse follows. A fresh 3×4 then gives 0x0C.
- **SIGNED_MUL_EN defined.**
  - x=−3 (0xD), y=5 → 0xF1 (−15).
  - x=−8, y=−8 → 0x40 (64).
  - x=−8, y=7 → 0xC8 (−56).
  - All with 4-cycle latency.
